// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, counter width
// and the default bit period for a 100 MHz clock at 115200 baud.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int COUNT_WIDTH          = 16;

  typedef enum logic [2:0] {
    s_IDLE         = 3'b000,
    s_RX_START_BIT = 3'b001,
    s_RX_DATA_BITS = 3'b010,
    s_RX_STOP_BIT  = 3'b011,
    s_CLEANUP      = 3'b100,
    s_BREAK_WAIT   = 3'b101
  } rx_state_t;

  // Mid-bit offset measured from the first low sample of the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset to
// the idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_Meta;
  logic r_Sync;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Meta <= 1'b1;
      r_Sync <= 1'b1;
    end else begin
      r_Meta <= i_Async;
      r_Sync <= r_Meta;
    end
  end

  assign o_Sync = r_Sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of start, eight LSB-first data bits and
// stop bit, with a one-cycle valid strobe or a one-cycle framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [COUNT_WIDTH-1:0] HALF_BIT   = COUNT_WIDTH'(half_bit(CLKS_PER_BIT));
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  logic                   w_Rx_Sync;
  rx_state_t              r_State;
  logic [COUNT_WIDTH-1:0] r_Clock_Count;
  logic [2:0]             r_Bit_Index;
  logic [7:0]             r_Rx_Data;
  logic [7:0]             r_Rx_Byte;
  logic                   r_Rx_DV;
  logic                   r_Rx_Active;
  logic                   r_Frame_Err;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (w_Rx_Sync)
  );

  // Strobes default low each cycle and are raised only on the STOP exit, so
  // DV and Frame_Err can never coincide.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State       <= s_IDLE;
      r_Clock_Count <= '0;
      r_Bit_Index   <= '0;
      r_Rx_Data     <= '0;
      r_Rx_Byte     <= '0;
      r_Rx_DV       <= 1'b0;
      r_Rx_Active   <= 1'b0;
      r_Frame_Err   <= 1'b0;
    end else begin
      r_Rx_DV     <= 1'b0;
      r_Frame_Err <= 1'b0;

      case (r_State)
        s_IDLE: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= '0;
          r_Rx_Active   <= 1'b0;
          if (!w_Rx_Sync) begin
            r_State     <= s_RX_START_BIT;
            r_Rx_Active <= 1'b1;
          end
        end

        s_RX_START_BIT: begin
          r_Rx_Active <= 1'b1;
          if (r_Clock_Count == HALF_BIT) begin
            r_Clock_Count <= '0;
            if (!w_Rx_Sync) begin
              r_State <= s_RX_DATA_BITS;
            end else begin
              r_State     <= s_IDLE;
              r_Rx_Active <= 1'b0;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + COUNT_ONE;
          end
        end

        s_RX_DATA_BITS: begin
          if (r_Clock_Count < LAST_COUNT) begin
            r_Clock_Count <= r_Clock_Count + COUNT_ONE;
          end else begin
            r_Clock_Count          <= '0;
            r_Rx_Data[r_Bit_Index] <= w_Rx_Sync;
            if (r_Bit_Index == 3'd7) begin
              r_Bit_Index <= '0;
              r_State     <= s_RX_STOP_BIT;
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end
          end
        end

        s_RX_STOP_BIT: begin
          if (r_Clock_Count < LAST_COUNT) begin
            r_Clock_Count <= r_Clock_Count + COUNT_ONE;
          end else begin
            r_Clock_Count <= '0;
            if (w_Rx_Sync) begin
              r_Rx_Byte <= r_Rx_Data;
              r_Rx_DV   <= 1'b1;
              r_State   <= s_CLEANUP;
            end else begin
              r_Frame_Err <= 1'b1;
              r_Rx_Active <= 1'b0;
              r_State     <= s_BREAK_WAIT;
            end
          end
        end

        s_CLEANUP: begin
          r_Clock_Count <= '0;
          r_Rx_Active   <= 1'b0;
          r_State       <= s_IDLE;
        end

        // A held-low line must not restart framing until it returns high.
        s_BREAK_WAIT: begin
          r_Clock_Count <= '0;
          r_Rx_Active   <= 1'b0;
          if (w_Rx_Sync) begin
            r_State <= s_IDLE;
          end
        end

        default: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= '0;
          r_Rx_Active   <= 1'b0;
          r_State       <= s_IDLE;
        end
      endcase
    end
  end

  assign o_Rx_DV        = r_Rx_DV;
  assign o_Rx_Byte      = r_Rx_Byte;
  assign o_Rx_Active    = r_Rx_Active;
  assign o_Rx_Frame_Err = r_Frame_Err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, start glitch,
// break, back-to-back frames, mid-frame reset and a 256-byte loopback sweep.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rxSerial;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       rxActive;
  logic       rxFrameErr;

  int checks;
  int errors;
  int dvCount;
  int feCount;
  int bothCount;
  logic [7:0] rxQueue[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rxSerial),
    .o_Rx_DV        (rxDv),
    .o_Rx_Byte      (rxByte),
    .o_Rx_Active    (rxActive),
    .o_Rx_Frame_Err (rxFrameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rxDv) begin
      dvCount++;
      rxQueue.push_back(rxByte);
    end
    if (rxFrameErr) feCount++;
    if (rxDv && rxFrameErr) bothCount++;
  end

  // Transmit one 8N1 frame, changing the line on falling edges.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    @(negedge clk) rxSerial = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxSerial = data[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rxSerial = stopBit;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int dvBase;
    int qBase;
    logic [7:0] partial;
    logic [31:0] got;

    checks    = 0;
    errors    = 0;
    dvCount   = 0;
    feCount   = 0;
    bothCount = 0;
    rst       = 1'b1;
    rxSerial  = 1'b1;

    #1;
    checkOutput("reset_dv", rxDv, 0);
    checkOutput("reset_byte", rxByte, 8'h00);
    checkOutput("reset_active", rxActive, 0);
    checkOutput("reset_frame_err", rxFrameErr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] test 1: single frame 0xA5");
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        repeat (80) @(negedge clk);
        checkOutput("t1_active_mid", rxActive, 1);
      end
    join
    repeat (4) @(negedge clk);
    checkOutput("t1_dv_count", dvCount, 1);
    checkOutput("t1_byte", rxByte, 8'hA5);
    checkOutput("t1_fe_count", feCount, 0);
    checkOutput("t1_active_after", rxActive, 0);

    $display("[TB] test 2: 5-clock start glitch");
    @(negedge clk) rxSerial = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk) rxSerial = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t2_dv_count", dvCount, 1);
    checkOutput("t2_fe_count", feCount, 0);
    checkOutput("t2_byte", rxByte, 8'hA5);
    checkOutput("t2_active", rxActive, 0);

    $display("[TB] test 3: framing error then break");
    applyStimulus(8'h3C, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    checkOutput("t3_active_in_break", rxActive, 0);
    repeat (20 * CPB) @(negedge clk);
    @(negedge clk) rxSerial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("t3_fe_count", feCount, 1);
    checkOutput("t3_dv_count", dvCount, 1);
    checkOutput("t3_byte_kept", rxByte, 8'hA5);
    applyStimulus(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("t3_dv_after_break", dvCount, 2);
    checkOutput("t3_byte_81", rxByte, 8'h81);

    $display("[TB] test 4: back-to-back frames");
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("t4_dv_count", dvCount, 5);
    checkOutput("t4_queue_size", rxQueue.size(), 5);
    if (rxQueue.size() >= 5) begin
      checkOutput("t4_byte0", rxQueue[2], 8'h00);
      checkOutput("t4_byte1", rxQueue[3], 8'hFF);
      checkOutput("t4_byte2", rxQueue[4], 8'h55);
    end
    checkOutput("t4_fe_count", feCount, 1);

    $display("[TB] test 5: reset during data bit 4");
    partial = 8'hC3;
    dvBase  = dvCount;
    @(negedge clk) rxSerial = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) rxSerial = partial[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rxSerial = partial[4];
    repeat (7) @(negedge clk);
    checkOutput("t5_active_before_reset", rxActive, 1);
    rst      = 1'b1;
    rxSerial = 1'b1;
    #1;
    checkOutput("t5_reset_dv", rxDv, 0);
    checkOutput("t5_reset_byte", rxByte, 8'h00);
    checkOutput("t5_reset_active", rxActive, 0);
    checkOutput("t5_reset_frame_err", rxFrameErr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("t5_no_strobe", dvCount, dvBase);
    applyStimulus(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("t5_dv_count", dvCount, dvBase + 1);
    checkOutput("t5_byte", rxByte, 8'h7E);

    $display("[TB] test 6: 256-byte loopback sweep");
    dvBase = dvCount;
    qBase  = rxQueue.size();
    for (int b = 0; b < 256; b++) begin
      applyStimulus(8'(b), 1'b1);
    end
    repeat (4) @(negedge clk);
    checkOutput("t6_dv_count", dvCount - dvBase, 256);
    checkOutput("t6_fe_count", feCount, 1);
    for (int b = 0; b < 256; b++) begin
      got = (qBase + b < rxQueue.size()) ? 32'(rxQueue[qBase + b]) : 32'hFFFF_FFFF;
      checkOutput("t6_byte", got, 32'(b));
    end

    checkOutput("never_dv_and_fe", bothCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
